// File: rtl/sr_flag_arbiter_if.sv
// rtl/sr_flag_arbiter_if.sv - request/grant and flag-bank bundle for sr_flag_arbiter
interface sr_flag_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int N_FLAGS = 8
);
    localparam int IDX_W = ($clog2(N_FLAGS) > 1) ? $clog2(N_FLAGS) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       op;
    logic [N_REQ*IDX_W-1:0] idx;
    logic [N_REQ-1:0]       gnt;
    logic [N_FLAGS-1:0]     flags;
    logic                   err;

    modport master (
        output req, op, idx,
        input  gnt, flags, err
    );

    modport slave (
        input  req, op, idx,
        output gnt, flags, err
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin set/clear arbiter over a flag bank (optional auto-clear: SR_FLAG_AUTOCLR_EN)
module sr_flag_arbiter #(
    parameter int N_REQ       = 4,
    parameter int N_FLAGS     = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sr_flag_arbiter_if.slave bus
);
    localparam int IDX_W = ($clog2(N_FLAGS) > 1) ? $clog2(N_FLAGS) : 1;
    localparam int PTR_W = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;

    // Parameter sanity checks at elaboration
    if (N_REQ < 2) begin : g_bad_nreq
        $error("sr_flag_arbiter: N_REQ must be >= 2");
    end
    if (N_FLAGS < 1) begin : g_bad_nflags
        $error("sr_flag_arbiter: N_FLAGS must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("sr_flag_arbiter: HOLD_CYCLES must be >= 1");
    end

    logic [PTR_W-1:0]   ptr;
    logic               win_valid;
    logic [PTR_W-1:0]   win_id;
    logic [N_REQ-1:0]   gnt_int;
    logic               grant_any;
    logic               g_op;
    logic [IDX_W-1:0]   g_idx;
    logic               in_range;
    logic [N_FLAGS-1:0] hit;
    logic [N_FLAGS-1:0] flags_q;
    logic               err_q;

    // Round-robin scan starting at ptr; descending loop so the closest requester to ptr wins
    always_comb begin
        int cand;
        win_valid = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (bus.req[cand]) begin
                win_valid = 1'b1;
                win_id    = PTR_W'(cand);
            end
        end
    end

    // One-hot grant, forced low while reset is asserted
    always_comb begin
        gnt_int = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_int[i] = rst_n & win_valid & (win_id == PTR_W'(i));
        end
    end

    assign grant_any = |gnt_int;
    assign bus.gnt   = gnt_int;

    // Select the winner's operation and flag index
    always_comb begin
        g_op  = 1'b0;
        g_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_int[i]) begin
                g_op  = bus.op[i];
                g_idx = bus.idx[i*IDX_W +: IDX_W];
            end
        end
    end

    assign in_range = (int'(g_idx) < N_FLAGS);

    // Decode the single flag touched by the granted op (none when out of range)
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_FLAGS; i++) begin
            hit[i] = grant_any & in_range & (g_idx == IDX_W'(i));
        end
    end

    // Pointer moves just past the winner; unchanged when nobody is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            if (win_id == PTR_W'(N_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= win_id + PTR_W'(1);
            end
        end
    end

    // Error pulse for a granted op whose index lies outside the flag bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= grant_any & ~in_range;
        end
    end

`ifdef SR_FLAG_AUTOCLR_EN
    localparam int CNT_W = ($clog2(HOLD_CYCLES + 1) > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt [N_FLAGS];

    // Explicit op wins; otherwise a set flag counts down its hold and clears when it runs out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            for (int i = 0; i < N_FLAGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_FLAGS; i++) begin
                if (hit[i]) begin
                    flags_q[i] <= g_op;
                    cnt[i]     <= g_op ? CNT_W'(HOLD_CYCLES) : '0;
                end else if (flags_q[i]) begin
                    if (cnt[i] <= CNT_W'(1)) begin
                        flags_q[i] <= 1'b0;
                        cnt[i]     <= '0;
                    end else begin
                        cnt[i] <= cnt[i] - CNT_W'(1);
                    end
                end
            end
        end
    end
`else
    // Flags persist until an explicit clear or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            for (int i = 0; i < N_FLAGS; i++) begin
                if (hit[i]) begin
                    flags_q[i] <= g_op;
                end
            end
        end
    end
`endif

    assign bus.flags = flags_q;
    assign bus.err   = err_q;

endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Round-robin controller that shares a bank of N_FLAGS set/reset flag bits between N_REQ requesters. Each cycle it grants at most one set-or-clear operation, so no flag ever sees simultaneous set and reset (the invalid SR combination cannot occur). It sits between software/agent request ports and the status-flag bank, and can optionally auto-clear flags after a hold time.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2)
- N_FLAGS, 8, number of flag bits (≥1, need not be a power of two)
- HOLD_CYCLES, 16, auto-clear hold time in cycles (≥1; used only with SR_FLAG_AUTOCLR_EN)
- IDX_W, derived: max(1, $clog2(N_FLAGS)); localparam, not overridable

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request, held until granted
- op  in  N_REQ  per-requester operation: 1 = set, 0 = clear
- idx  in  N_REQ*IDX_W  per-requester flag index, requester i at bits [i*IDX_W +: IDX_W]
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as accepted req
- flags  out  N_FLAGS  registered flag bank
- err  out  1  registered one-cycle pulse: granted op had idx ≥ N_FLAGS

## Operation
- Reset: flags = 0, err = 0, round-robin pointer ptr = 0, all hold counters = 0. gnt = 0 while rst_n low.
- Arbitration: scan requesters from ptr upward, wrapping at N_REQ-1 → 0; first with req=1 wins; gnt = one-hot of winner; gnt = 0 if no req.
- Pointer: on a grant to requester w, ptr ← (w+1) mod N_REQ at the next edge; no grant → ptr unchanged.
- Handshake: a request completes in the cycle gnt[i]=1; requester may drop or change req/op/idx the following cycle. Ungranted requests must stay stable.
- Apply: granted op updates flags[idx] at the same edge; set → 1, clear → 0. Set on a set flag and clear on a clear flag leave the value unchanged (no error).
- Out-of-range: idx ≥ N_FLAGS is still granted (ptr advances), flags unchanged, err = 1 for the following cycle.
- At most one flag changes per cycle by request; all other flags hold.
- Reset asserted mid-operation: all state clears immediately; pending requests are lost and must be re-presented after reset release.

## Timing
- Grant latency: 0 cycles (gnt combinational from req, ptr).
- Flag/err latency: 1 cycle after grant (visible after the granting edge).
- Throughput: one operation per cycle; with all N_REQ requesting continuously, each requester is granted exactly once every N_REQ cycles.
- No combinational path from idx/op to flags or err.

## Configuration
- Macro SR_FLAG_AUTOCLR_EN.
- Defined: each flag has a counter of width $clog2(HOLD_CYCLES+1). A granted set loads HOLD_CYCLES (also on an already-set flag: hold restarts). Counter decrements each cycle while the flag is 1; when it reaches 0 the flag clears at that edge. A flag set at edge t reads 1 for exactly HOLD_CYCLES cycles, then 0. A granted explicit op to that flag in the expiry cycle takes priority (set reloads; clear clears and zeroes counter). Explicit clear zeroes the counter.
- Undefined: no counters instantiated; HOLD_CYCLES ignored; flags persist until explicitly cleared or reset.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111 → gnt=0, flags=0, err=0; release → first grant gnt=4'b0001.
- Round-robin: N_REQ=4, req=4'b1111 held 8 cycles → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Set/clear: req0 set idx=3, then req1 clear idx=3 → flags=8'h08 one cycle after first grant, 8'h00 after second; req0 and req1 same cycle with ptr=0 → only req0 granted, req1 granted next cycle.
- Out-of-range: N_FLAGS=6, req2 set idx=7 → gnt=4'b0100, flags unchanged, err=1 for exactly one cycle, ptr=3.
- Async reset mid-stream: drop rst_n between edges during continuous traffic → flags, err, gnt go to 0 immediately; after release arbitration restarts at requester 0.
- Auto-clear (SR_FLAG_AUTOCLR_EN, HOLD_CYCLES=4): set idx=1 → flags[1]=1 for 4 cycles then 0; re-set at cycle 2 → stays 1 for 4 cycles from re-set; clear in expiry cycle → 0, no re-set; without macro flag stays 1 for 100 cycles.
